// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: coin-slot input, spend/clear requests from the vending core,
// and the coin/credit/status outputs.
interface coin_acceptor_if;
  logic       coin_raw;
  logic       spend;
  logic [6:0] spend_amt;
  logic       credit_clear;
  logic       coin_valid;
  logic       spend_ack;
  logic       spend_nack;
  logic [6:0] credit;
  logic [3:0] credit_tens;
  logic [3:0] credit_ones;
  logic       jam;

  modport slave (
    input  coin_raw, spend, spend_amt, credit_clear,
    output coin_valid, spend_ack, spend_nack, credit, credit_tens, credit_ones, jam
  );

  modport master (
    output coin_raw, spend, spend_amt, credit_clear,
    input  coin_valid, spend_ack, spend_nack, credit, credit_tens, credit_ones, jam
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes coin_raw, qualifies pulse width with lockout
// and jam detection, and keeps a saturating credit register with BCD view.
module coin_acceptor #(
  parameter int MIN_HIGH   = 4,
  parameter int MAX_HIGH   = 200,
  parameter int LOCKOUT    = 8,
  parameter int CREDIT_MAX = 99
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  localparam logic [7:0] MIN_HIGH_C   = 8'(MIN_HIGH);
  localparam logic [7:0] MAX_HIGH_C   = 8'(MAX_HIGH);
  localparam logic [7:0] LOCKOUT_C    = 8'(LOCKOUT);
  localparam logic [6:0] CREDIT_MAX_C = 7'(CREDIT_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOCK = 2'd2,
    S_JAM  = 2'd3
  } state_e;

  // Adds the accepted coin and clamps at the credit ceiling.
  function automatic logic [6:0] sat_add(input logic [6:0] base, input logic inc);
    logic [7:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    return (sum > {1'b0, CREDIT_MAX_C}) ? CREDIT_MAX_C : sum[6:0];
  endfunction

  // Packs {tens, ones}; credit never exceeds 99 so tens fits the upper nibble.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return ((8'(v) / 8'd10) << 4) | (8'(v) % 8'd10);
  endfunction

  logic       sync1_q, sync2_q;
  logic       coin_s;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept_s;
  logic [6:0] credit_q, credit_d;
  logic       coin_valid_q;
  logic       spend_ack_q, spend_ack_d;
  logic       spend_nack_q, spend_nack_d;
  logic       jam_q;
  logic [7:0] bcd_s;

  assign coin_s = sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.coin_raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // LOCKOUT and JAM share the quiet-count rule; any high sample restarts the count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_s) begin
          state_d = S_HIGH;
          cnt_d   = 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HIGH: begin
        if (coin_s) begin
          if (cnt_q + 8'd1 == MAX_HIGH_C) begin
            state_d = S_JAM;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (cnt_q >= MIN_HIGH_C) begin
          accept_s = 1'b1;
          state_d  = S_LOCK;
          cnt_d    = 8'd0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      S_LOCK, S_JAM: begin
        if (coin_s) begin
          cnt_d = 8'd0;
        end else if (cnt_q + 8'd1 == LOCKOUT_C) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Clear beats spend; a coin accepted in the same cycle never rescues a refused spend.
  always_comb begin
    credit_d     = credit_q;
    spend_ack_d  = 1'b0;
    spend_nack_d = 1'b0;
    if (bus.credit_clear) begin
      credit_d     = accept_s ? 7'd1 : 7'd0;
      spend_nack_d = bus.spend;
    end else if (bus.spend) begin
      if (bus.spend_amt <= credit_q) begin
        spend_ack_d = 1'b1;
        credit_d    = sat_add(credit_q - bus.spend_amt, accept_s);
      end else begin
        spend_nack_d = 1'b1;
        credit_d     = sat_add(credit_q, accept_s);
      end
    end else begin
      credit_d = sat_add(credit_q, accept_s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q     <= 7'd0;
      coin_valid_q <= 1'b0;
      spend_ack_q  <= 1'b0;
      spend_nack_q <= 1'b0;
      jam_q        <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      coin_valid_q <= accept_s;
      spend_ack_q  <= spend_ack_d;
      spend_nack_q <= spend_nack_d;
      jam_q        <= (state_d == S_JAM);
    end
  end

  assign bcd_s           = to_bcd(credit_q);
  assign bus.credit_tens = bcd_s[7:4];
  assign bus.credit_ones = bcd_s[3:0];
  assign bus.credit      = credit_q;
  assign bus.coin_valid  = coin_valid_q;
  assign bus.spend_ack   = spend_ack_q;
  assign bus.spend_nack  = spend_nack_q;
  assign bus.jam         = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: a credit model predicts each output event,
// a monitor pops and compares whenever the DUT pulses an output.
module tb_coin_acceptor;
  localparam int CMAX = 99;

  logic clk = 1'b0;
  logic reset = 1'b1;
  coin_acceptor_if bus();

  coin_acceptor #(.MIN_HIGH(4), .MAX_HIGH(200), .LOCKOUT(8), .CREDIT_MAX(CMAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit cv;
    bit ack;
    bit nack;
    int credit;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail = 0;

  int m_credit = 0;
  bit m_locked = 1'b0;
  int m_prev_gap = 99;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Credit rules in plain arithmetic; pushes the expected output event, if any.
  task automatic model_op(input bit clr, input bit sp, input int amt, input bit coin);
    exp_t e;
    int c;
    c = m_credit;
    e.cv = coin; e.ack = 1'b0; e.nack = 1'b0;
    if (clr) begin
      e.nack = sp;
      c = coin ? 1 : 0;
    end else if (sp && amt <= c) begin
      e.ack = 1'b1;
      c = c - amt + (coin ? 1 : 0);
    end else begin
      e.nack = sp;
      c = c + (coin ? 1 : 0);
    end
    if (c > CMAX) c = CMAX;
    e.credit = c;
    m_credit = c;
    if (sp || coin) sbq.push_back(e);
  endtask

  // Coin acceptance decided from pulse width and the quiet gap before it.
  task automatic coin_pulse(input int w, input int g);
    bit locked_now;
    locked_now = m_locked && (m_prev_gap < 12);
    bus.coin_raw = 1'b1;
    repeat (w) @(negedge clk);
    bus.coin_raw = 1'b0;
    if (locked_now) begin
      m_locked = 1'b1;
    end else if (w >= 4 && w < 200) begin
      model_op(1'b0, 1'b0, 0, 1'b1);
      m_locked = 1'b1;
    end else begin
      m_locked = 1'b0;
    end
    repeat (g) @(negedge clk);
    m_prev_gap = g;
  endtask

  task automatic spend_op(input bit clr, input bit sp, input int amt);
    bus.credit_clear = clr;
    bus.spend = sp;
    bus.spend_amt = 7'(amt);
    model_op(clr, sp, amt, 1'b0);
    @(negedge clk);
    bus.credit_clear = 1'b0;
    bus.spend = 1'b0;
  endtask

  // Request lands on the same edge that accepts the coin.
  task automatic coin_with_op(input bit clr, input bit sp, input int amt);
    bus.coin_raw = 1'b1;
    repeat (6) @(negedge clk);
    bus.coin_raw = 1'b0;
    repeat (2) @(negedge clk);
    bus.credit_clear = clr;
    bus.spend = sp;
    bus.spend_amt = 7'(amt);
    model_op(clr, sp, amt, 1'b1);
    m_locked = 1'b1;
    @(negedge clk);
    bus.credit_clear = 1'b0;
    bus.spend = 1'b0;
    repeat (14) @(negedge clk);
    m_prev_gap = 15;
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && (bus.coin_valid || bus.spend_ack || bus.spend_nack)) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: cv=%0d ack=%0d nack=%0d credit=%0d required none at %0t",
                 bus.coin_valid, bus.spend_ack, bus.spend_nack, bus.credit, $time);
      end else begin
        mon_e = sbq.pop_front();
        check("mon_coin_valid", int'(bus.coin_valid), int'(mon_e.cv));
        check("mon_spend_ack", int'(bus.spend_ack), int'(mon_e.ack));
        check("mon_spend_nack", int'(bus.spend_nack), int'(mon_e.nack));
        check("mon_credit", int'(bus.credit), mon_e.credit);
        check("mon_tens", int'(bus.credit_tens), mon_e.credit / 10);
        check("mon_ones", int'(bus.credit_ones), mon_e.credit % 10);
      end
    end
  end

  initial begin
    int iter;
    int w;
    int g;
    bus.coin_raw = 1'b0;
    bus.spend = 1'b0;
    bus.spend_amt = 7'd0;
    bus.credit_clear = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_coin_valid", int'(bus.coin_valid), 0);
    check("rst_spend_ack", int'(bus.spend_ack), 0);
    check("rst_spend_nack", int'(bus.spend_nack), 0);
    check("rst_jam", int'(bus.jam), 0);
    check("rst_credit", int'(bus.credit), 0);
    check("rst_tens", int'(bus.credit_tens), 0);
    check("rst_ones", int'(bus.credit_ones), 0);
    repeat (2) @(negedge clk);

    // Single coin with exact latency from the falling sample.
    bus.coin_raw = 1'b1;
    repeat (6) @(negedge clk);
    bus.coin_raw = 1'b0;
    model_op(1'b0, 1'b0, 0, 1'b1);
    m_locked = 1'b1;
    repeat (2) @(negedge clk);
    check("coin_latency_early", int'(bus.coin_valid), 0);
    @(negedge clk);
    check("coin_latency", int'(bus.coin_valid), 1);
    repeat (12) @(negedge clk);
    m_prev_gap = 15;

    coin_pulse(3, 15);
    check("width3_rejected", int'(bus.credit), 1);
    coin_pulse(4, 15);
    check("width4_accepted", int'(bus.credit), 2);

    coin_pulse(6, 3);
    coin_pulse(6, 15);
    check("lockout_gap3", int'(bus.credit), 3);
    coin_pulse(6, 12);
    coin_pulse(6, 15);
    check("lockout_gap12", int'(bus.credit), 5);

    spend_op(1'b0, 1'b1, 3);
    spend_op(1'b0, 1'b1, 4);
    spend_op(1'b0, 1'b1, 0);
    @(negedge clk);
    check("spend_credit2", int'(bus.credit), 2);
    repeat (4) @(negedge clk);
    coin_with_op(1'b1, 1'b1, 1);
    check("clear_with_coin", int'(bus.credit), 1);

    // Random coin pulses until saturated, plus a few beyond.
    iter = 0;
    while (iter < 800 && m_credit < CMAX) begin
      w = int'($urandom_range(1, 10));
      g = ($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(12, 18));
      coin_pulse(w, g);
      iter++;
    end
    for (int i = 0; i < 3; i++) coin_pulse(int'($urandom_range(4, 8)), 14);
    repeat (15) @(negedge clk);
    m_prev_gap = 15;
    check("credit_saturated", int'(bus.credit), 99);

    coin_pulse(6, 15);
    check("sat_coin_credit", int'(bus.credit), 99);
    coin_with_op(1'b0, 1'b1, 10);
    check("sat_coin_spend10", int'(bus.credit), 90);

    // Random spends and clears against the model.
    for (int i = 0; i < 60; i++) begin
      spend_op(($urandom % 12) == 0, ($urandom % 3) != 0,
               int'($urandom_range(0, 32'(m_credit + 10))));
    end
    repeat (2) @(negedge clk);
    check("random_spend_credit", int'(bus.credit), m_credit);

    // Jam: held high far past MAX_HIGH, then released.
    bus.coin_raw = 1'b1;
    for (int n = 1; n <= 250; n++) begin
      @(negedge clk);
      if (n == 201) check("jam_before_max", int'(bus.jam), 0);
      if (n == 202) check("jam_at_max", int'(bus.jam), 1);
    end
    bus.coin_raw = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 9) check("jam_held_quiet", int'(bus.jam), 1);
      if (n == 10) check("jam_released", int'(bus.jam), 0);
    end
    check("jam_no_credit", int'(bus.credit), m_credit);
    m_locked = 1'b0;
    repeat (3) @(negedge clk);
    coin_pulse(6, 15);
    check("coin_after_jam", int'(bus.credit), m_credit);

    // Reset in the middle of a coin pulse discards it.
    bus.coin_raw = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.coin_raw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_credit = 0;
    m_locked = 1'b0;
    m_prev_gap = 99;
    check("midreset_credit", int'(bus.credit), 0);
    check("midreset_jam", int'(bus.jam), 0);
    repeat (6) @(negedge clk);
    check("midreset_no_coin", int'(bus.credit), 0);
    coin_pulse(5, 15);
    check("coin_after_reset", int'(bus.credit), 1);

    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected events never seen, required 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage for the vending machine's money input. It turns the raw coin-slot signal into validated single-cycle coin events and keeps a saturating credit register. The vending core spends from that register and clears it. It runs on the divided clock alongside the debouncers. It also presents credit as two BCD digits for the seven-segment path.

## Interface
- MIN_HIGH, 4: minimum synchronized high time, in cycles, for a pulse to count as a coin.
- MAX_HIGH, 200: high time, in cycles, at which the slot is declared jammed.
- LOCKOUT, 8: quiet cycles required after a coin or jam before re-arming.
- CREDIT_MAX, 99: credit saturation value (must be ≤ 99).

Ports:
- clk  in  1  the single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- coin_raw  in  1  asynchronous coin-slot signal.
- spend  in  1  single-cycle request to deduct spend_amt.
- spend_amt  in  7  unsigned amount, sampled when spend=1.
- credit_clear  in  1  single-cycle request to zero credit.
- coin_valid  out  1  single-cycle pulse, one per accepted coin.
- spend_ack  out  1  single-cycle pulse: deduction performed.
- spend_nack  out  1  single-cycle pulse: deduction refused, credit unchanged.
- credit  out  7  current credit, binary, range 0..CREDIT_MAX.
- credit_tens  out  4  BCD tens digit of credit (combinational from credit).
- credit_ones  out  4  BCD ones digit of credit (combinational from credit).
- jam  out  1  high while in JAM.

## Operation
- **Synchronizer:** 2-FF on coin_raw produces coin_s. Both FFs reset to 0.
- **FSM states** (reset → IDLE), with a 8-bit counter cnt that resets to 0:
  - IDLE, coin_s=1 → HIGH, cnt=1.
  - HIGH, coin_s=1 → cnt+1. If cnt+1 reaches MAX_HIGH → JAM, cnt=0.
  - HIGH, coin_s=0 and cnt≥MIN_HIGH → accept coin, → LOCKOUT, cnt=0.
  - HIGH, coin_s=0 and cnt<MIN_HIGH → glitch: → IDLE, no credit change.
  - LOCKOUT: cnt counts consecutive coin_s=0 cycles, and coin_s=1 resets cnt to 0. At cnt=LOCKOUT → IDLE. A pulse inside LOCKOUT is never credited.
  - JAM: same quiet-count rule as LOCKOUT, then → IDLE. jam=1 throughout JAM, and jam is registered from the state.
- **Accept:** coin_valid=1 for exactly one cycle and credit+1, saturating at CREDIT_MAX. coin_valid still pulses when credit is saturated.
- **Credit update priority,** evaluated in one cycle against the pre-edge credit C:
  1. credit_clear: new credit = (coin accepted ? 1 : 0). A spend in the same cycle gets spend_nack.
  2. spend with spend_amt ≤ C: new credit = min(C − spend_amt + coin, CREDIT_MAX), with spend_ack.
  3. spend with spend_amt > C: spend_nack, and new credit = min(C + coin, CREDIT_MAX). A coin arriving in the same cycle does not rescue the spend.
- spend_amt=0 gives ack with no change.
- **BCD:** credit_tens = credit/10 and credit_ones = credit%10, pure combinational from the credit register.

## Timing
- **Reset values:** coin_valid, spend_ack, spend_nack and jam are 0; credit is 0; BCD outputs are 0/0; state is IDLE; the synchronizer is 0.
- **Reset mid-operation:** reset has priority over every input. A coin in progress is discarded.
- **Input latency:** coin_raw change sampled at edge k appears on coin_s after edge k+1.
- **Coin latency:** coin_valid and the credit increment are visible after edge k+2, where k is the edge that first samples coin_raw low.
- **High time:** cnt equals the number of cycles coin_s was high. A pulse with exactly MIN_HIGH cycles is accepted, and MIN_HIGH−1 is rejected.
- **Jam detection:** jam rises after the edge where the MAX_HIGH-th consecutive high cycle is counted.
- **Spend and clear:** spend_ack/spend_nack and the credit change appear after the same edge that samples spend. There is one-cycle latency, with no back-pressure, and spend is honoured every cycle.
- **Re-arm:** earliest is LOCKOUT+1 cycles after the accepting edge, provided coin_s stays low.

## Test plan
- **Single coin:** reset, then coin_raw high for 6 cycles → one coin_valid pulse 2 cycles after the fall; credit=1, tens=0, ones=1.
- **Width boundaries:** pulse of 3 cycles → no coin_valid, credit unchanged. Pulse of 4 cycles → accepted.
- **Lockout:** two 6-cycle pulses 3 cycles apart → only first credited. With the gap 12 cycles → both credited, credit=2.
- **Jam:** coin_raw held high 250 cycles → jam=1 after 200 high cycles, no credit. Release → jam=0 after 8 quiet cycles, then a normal coin is credited.
- **Spend and clear:**
  - credit=5: spend_amt=3 → ack, credit=2.
  - spend_amt=4 → nack, credit stays 2.
  - credit_clear with a simultaneous coin accept → credit=1.
- **Saturation:** credit=99 plus coin → coin_valid pulses, credit=99 (9/9). Same-cycle coin and spend_amt=10 at credit=99 → ack, credit=90.
